// File: rtl/benes_route_scheduler.sv
// rtl/benes_route_scheduler.sv - switch-config sequencer for the dual Benes network; define BENES_SCHED_PERF_EN for launch/reconfig counters
module benes_route_scheduler #(
  parameter int STAGE_NUM   = 9,
  parameter int SWITCH_NUM  = 16,
  parameter int CFG_DEPTH   = 8,
  parameter int CFG_AW      = $clog2(CFG_DEPTH),
  parameter int TAG_W       = 4,
  parameter int NET_LATENCY = 12
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            CFG_WE,
  input  logic [CFG_AW-1:0]               CFG_ADDR,
  input  logic [STAGE_NUM*SWITCH_NUM-1:0] CFG_MODULE_SEL,
  input  logic [STAGE_NUM*SWITCH_NUM-1:0] CFG_SLOT_SEL,
  input  logic                            REQ_VALID,
  output logic                            REQ_READY,
  input  logic [CFG_AW-1:0]               REQ_IDX,
  input  logic [TAG_W-1:0]                REQ_TAG,
  output logic [STAGE_NUM*SWITCH_NUM-1:0] O_MODULE_SELECT,
  output logic [STAGE_NUM*SWITCH_NUM-1:0] O_SLOT_SELECT,
  output logic                            O_LAUNCH,
  output logic                            O_DONE_VALID,
  output logic [TAG_W-1:0]                O_DONE_TAG,
  output logic                            O_BUSY,
`ifdef BENES_SCHED_PERF_EN
  output logic [31:0]                     O_LAUNCH_CNT,
  output logic [31:0]                     O_RECONF_CNT,
`endif
  output logic                            O_CFG_ERR
);

  localparam int SEL_W = STAGE_NUM * SWITCH_NUM;
  localparam int CNT_W = $clog2(NET_LATENCY + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2} state_t;

  state_t              state;
  logic [CFG_AW-1:0]   cur_idx;
  logic [SEL_W-1:0]    tbl_module [CFG_DEPTH];
  logic [SEL_W-1:0]    tbl_slot   [CFG_DEPTH];
  logic [CFG_DEPTH-1:0] tbl_valid;
  logic [TAG_W-1:0]    launch_tag;
  logic [NET_LATENCY-1:0] pipe_valid;
  logic [TAG_W-1:0]    pipe_tag [NET_LATENCY];
  logic [CNT_W-1:0]    inflight;
  logic [CNT_W-1:0]    inflight_next;

  logic req_ready;
  logic accept;
  logic wr_blocked;
  logic wr_commit;
  logic bypass;
  logic entry_ok;
  logic idle_launch;

  // Ready depends on the active index so a new config can never slip in while streaming
  always_comb begin
    req_ready = 1'b0;
    if (!RST) begin
      case (state)
        IDLE:    req_ready = 1'b1;
        STREAM:  req_ready = (REQ_IDX == cur_idx);
        default: req_ready = 1'b0;
      endcase
    end
  end

  assign REQ_READY   = req_ready;
  assign accept      = REQ_VALID && req_ready;
  // The entry driving the network must stay intact until the network is empty again
  assign wr_blocked  = CFG_WE && (state != IDLE) && (CFG_ADDR == cur_idx);
  assign wr_commit   = CFG_WE && !wr_blocked;
  assign bypass      = CFG_WE && (CFG_ADDR == REQ_IDX);
  assign entry_ok    = tbl_valid[REQ_IDX] || bypass;
  assign idle_launch = (state == IDLE) && accept && entry_ok;

  assign O_BUSY       = (state != IDLE) || (inflight != '0);
  assign O_DONE_VALID = pipe_valid[NET_LATENCY-1];
  assign O_DONE_TAG   = pipe_tag[NET_LATENCY-1];

  // Next in-flight count; DRAIN looks ahead so it leaves on the cycle the last transfer exits
  always_comb begin
    inflight_next = inflight;
    if (O_LAUNCH && !O_DONE_VALID) begin
      inflight_next = inflight + CNT_W'(1);
    end else if (!O_LAUNCH && O_DONE_VALID) begin
      inflight_next = inflight - CNT_W'(1);
    end
  end

  // Configuration table with per-entry valid bits
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tbl_valid <= '0;
      for (int i = 0; i < CFG_DEPTH; i++) begin
        tbl_module[i] <= '0;
        tbl_slot[i]   <= '0;
      end
    end else if (wr_commit) begin
      tbl_valid[CFG_ADDR]  <= 1'b1;
      tbl_module[CFG_ADDR] <= CFG_MODULE_SEL;
      tbl_slot[CFG_ADDR]   <= CFG_SLOT_SEL;
    end
  end

  // Latency pipe mirrors the network: each launch re-emerges as a done NET_LATENCY cycles later
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pipe_valid <= '0;
      for (int i = 0; i < NET_LATENCY; i++) begin
        pipe_tag[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= O_LAUNCH;
      pipe_tag[0]   <= O_LAUNCH ? launch_tag : '0;
      for (int i = 1; i < NET_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_tag[i]   <= pipe_tag[i-1];
      end
    end
  end

  // In-flight transfer counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      inflight <= '0;
    end else begin
      inflight <= inflight_next;
    end
  end

  // Scheduler FSM with registered selects, launch strobe and error pulse
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state           <= IDLE;
      cur_idx         <= '0;
      O_MODULE_SELECT <= '0;
      O_SLOT_SELECT   <= '0;
      O_LAUNCH        <= 1'b0;
      launch_tag      <= '0;
      O_CFG_ERR       <= 1'b0;
    end else begin
      O_LAUNCH  <= 1'b0;
      O_CFG_ERR <= wr_blocked;
      case (state)
        IDLE: begin
          if (accept) begin
            if (entry_ok) begin
              state      <= STREAM;
              cur_idx    <= REQ_IDX;
              O_LAUNCH   <= 1'b1;
              launch_tag <= REQ_TAG;
              if (bypass) begin
                O_MODULE_SELECT <= CFG_MODULE_SEL;
                O_SLOT_SELECT   <= CFG_SLOT_SEL;
              end else begin
                O_MODULE_SELECT <= tbl_module[REQ_IDX];
                O_SLOT_SELECT   <= tbl_slot[REQ_IDX];
              end
            end else begin
              O_CFG_ERR <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            O_LAUNCH   <= 1'b1;
            launch_tag <= REQ_TAG;
          end else if (REQ_VALID) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (inflight_next == '0) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BENES_SCHED_PERF_EN
  // Saturating counters of launches and of new-configuration starts
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      O_LAUNCH_CNT <= '0;
      O_RECONF_CNT <= '0;
    end else begin
      if (O_LAUNCH && (O_LAUNCH_CNT != 32'hFFFF_FFFF)) begin
        O_LAUNCH_CNT <= O_LAUNCH_CNT + 32'd1;
      end
      if (idle_launch && (O_RECONF_CNT != 32'hFFFF_FFFF)) begin
        O_RECONF_CNT <= O_RECONF_CNT + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_benes_route_scheduler.sv
// tb/tb_benes_route_scheduler.sv - self-checking bench for benes_route_scheduler
module tb_benes_route_scheduler;
  localparam int STAGE_NUM   = 9;
  localparam int SWITCH_NUM  = 16;
  localparam int CFG_DEPTH   = 8;
  localparam int CFG_AW      = 3;
  localparam int TAG_W       = 4;
  localparam int NET_LATENCY = 12;
  localparam int SEL_W       = STAGE_NUM * SWITCH_NUM;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              CFG_WE = 1'b0;
  logic [CFG_AW-1:0] CFG_ADDR = '0;
  logic [SEL_W-1:0]  CFG_MODULE_SEL = '0;
  logic [SEL_W-1:0]  CFG_SLOT_SEL = '0;
  logic              REQ_VALID = 1'b0;
  logic              REQ_READY;
  logic [CFG_AW-1:0] REQ_IDX = '0;
  logic [TAG_W-1:0]  REQ_TAG = '0;
  logic [SEL_W-1:0]  O_MODULE_SELECT;
  logic [SEL_W-1:0]  O_SLOT_SELECT;
  logic              O_LAUNCH;
  logic              O_DONE_VALID;
  logic [TAG_W-1:0]  O_DONE_TAG;
  logic              O_BUSY;
  logic              O_CFG_ERR;
`ifdef BENES_SCHED_PERF_EN
  logic [31:0]       launch_cnt;
  logic [31:0]       reconf_cnt;
`endif

  benes_route_scheduler dut (
    .CLK(CLK), .RST(RST),
    .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR),
    .CFG_MODULE_SEL(CFG_MODULE_SEL), .CFG_SLOT_SEL(CFG_SLOT_SEL),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_IDX(REQ_IDX), .REQ_TAG(REQ_TAG),
    .O_MODULE_SELECT(O_MODULE_SELECT), .O_SLOT_SELECT(O_SLOT_SELECT),
    .O_LAUNCH(O_LAUNCH), .O_DONE_VALID(O_DONE_VALID), .O_DONE_TAG(O_DONE_TAG),
    .O_BUSY(O_BUSY),
`ifdef BENES_SCHED_PERF_EN
    .O_LAUNCH_CNT(launch_cnt), .O_RECONF_CNT(reconf_cnt),
`endif
    .O_CFG_ERR(O_CFG_ERR)
  );

  always #10 CLK = ~CLK;

  typedef struct packed {
    logic [31:0]      cyc;
    logic [TAG_W-1:0] tag;
  } done_t;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic wr_drop = 1'b0;

  // reference model: table contents and expected completions
  logic [SEL_W-1:0] m_mod  [CFG_DEPTH];
  logic [SEL_W-1:0] m_slot [CFG_DEPTH];
  logic [CFG_DEPTH-1:0] m_valid = '0;
  done_t done_q[$];

  task automatic check1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [SEL_W-1:0] obs, input logic [SEL_W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SEL_W-1:0] rnd_sel();
    logic [159:0] v;
    v = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return v[SEL_W-1:0];
  endfunction

  // one clock: predict from the model, advance, then compare launch/error/done
  task automatic tick();
    logic acc, launch_exp, err_exp, wr_apply, dv_exp;
    logic [CFG_AW-1:0] a_idx;
    logic [TAG_W-1:0]  a_tag, dt_exp;
    done_t d;
    #2;
    acc        = REQ_VALID && REQ_READY;
    a_idx      = REQ_IDX;
    a_tag      = REQ_TAG;
    wr_apply   = CFG_WE && !wr_drop;
    launch_exp = acc && (m_valid[a_idx] || (wr_apply && (CFG_ADDR == a_idx)));
    err_exp    = (CFG_WE && wr_drop) || (acc && !launch_exp);
    if (wr_apply) begin
      m_valid[CFG_ADDR] = 1'b1;
      m_mod[CFG_ADDR]   = CFG_MODULE_SEL;
      m_slot[CFG_ADDR]  = CFG_SLOT_SEL;
    end
    @(posedge CLK);
    #1;
    cyc++;
    if (launch_exp) begin
      d.cyc = 32'(cyc + NET_LATENCY);
      d.tag = a_tag;
      done_q.push_back(d);
    end
    check1("launch", O_LAUNCH, launch_exp);
    check1("cfg_err", O_CFG_ERR, err_exp);
    dv_exp = 1'b0;
    dt_exp = '0;
    if (done_q.size() != 0 && done_q[0].cyc == 32'(cyc)) begin
      dv_exp = 1'b1;
      dt_exp = done_q[0].tag;
      void'(done_q.pop_front());
    end
    check1("done_valid", O_DONE_VALID, dv_exp);
    if (dv_exp) checkn("done_tag", int'(O_DONE_TAG), int'(dt_exp));
  endtask

  task automatic write_cfg(input logic [CFG_AW-1:0] idx, input logic [SEL_W-1:0] m,
                           input logic [SEL_W-1:0] s, input logic drop);
    CFG_WE = 1'b1; CFG_ADDR = idx; CFG_MODULE_SEL = m; CFG_SLOT_SEL = s; wr_drop = drop;
    tick();
    CFG_WE = 1'b0; wr_drop = 1'b0;
  endtask

  // present a request, wait (bounded) for ready, return the launch window
  task automatic send(input logic [CFG_AW-1:0] idx, input logic [TAG_W-1:0] tag,
                      input int budget, output int lcyc);
    int n;
    n = 0;
    REQ_VALID = 1'b1; REQ_IDX = idx; REQ_TAG = tag;
    #1;
    while (!REQ_READY && n < budget) begin
      tick();
      n++;
    end
    check1("ready_within_budget", REQ_READY, 1'b1);
    tick();
    lcyc = cyc;
    REQ_VALID = 1'b0;
  endtask

  initial begin
    logic [SEL_W-1:0] ones, fives, bm, bs;
    int l, last3, l5;
    ones  = '1;
    fives = {36{4'h5}};

    // reset state
    repeat (3) @(posedge CLK);
    #1;
    check1("rst_ready", REQ_READY, 1'b0);
    check1("rst_launch", O_LAUNCH, 1'b0);
    check1("rst_done", O_DONE_VALID, 1'b0);
    check1("rst_busy", O_BUSY, 1'b0);
    check1("rst_err", O_CFG_ERR, 1'b0);
    checkw("rst_mod", O_MODULE_SELECT, '0);
    checkw("rst_slot", O_SLOT_SELECT, '0);
`ifdef BENES_SCHED_PERF_EN
    checkn("rst_launch_cnt", int'(launch_cnt), 0);
    checkn("rst_reconf_cnt", int'(reconf_cnt), 0);
`endif
    RST = 1'b0;
    #1;
    check1("idle_ready", REQ_READY, 1'b1);

    // scenario 1: single transfer on entry 3
    write_cfg(3'd3, ones, fives, 1'b0);
    write_cfg(3'd5, rnd_sel(), rnd_sel(), 1'b0);
    send(3'd3, 4'hA, 4, l);
    checkw("s1_mod", O_MODULE_SELECT, ones);
    checkw("s1_slot", O_SLOT_SELECT, fives);
    repeat (13) tick();
    check1("s1_busy_stream", O_BUSY, 1'b1);

    // scenario 2: four back-to-back launches
    for (int t = 1; t <= 4; t++) begin
      send(3'd3, 4'(t), 4, last3);
      checkw("s2_mod_const", O_MODULE_SELECT, ones);
      checkw("s2_slot_const", O_SLOT_SELECT, fives);
    end

    // scenario 3: switch to entry 5 through DRAIN
    REQ_VALID = 1'b1; REQ_IDX = 3'd5; REQ_TAG = 4'h5;
    #1;
    check1("s3_ready_other_idx", REQ_READY, 1'b0);
    tick();
    check1("s3_busy_drain", O_BUSY, 1'b1);
    checkw("s3_mod_hold", O_MODULE_SELECT, ones);
    send(3'd5, 4'h5, 40, l5);
    checkn("s3_reconf_gap", l5 - last3, NET_LATENCY + 2);
    checkw("s3_mod", O_MODULE_SELECT, m_mod[5]);
    checkw("s3_slot", O_SLOT_SELECT, m_slot[5]);
    tick();
`ifdef BENES_SCHED_PERF_EN
    checkn("perf_launch_cnt", int'(launch_cnt), 6);
    checkn("perf_reconf_cnt", int'(reconf_cnt), 2);
`endif

    // scenario 4a: unwritten entry is consumed with an error pulse
    send(3'd6, 4'h6, 40, l);
    tick();
    check1("s4_idle_busy", O_BUSY, 1'b0);
    check1("s4_idle_ready", REQ_READY, 1'b1);

    // scenario 4b: write to the active entry is rejected
    send(3'd3, 4'hB, 4, l);
    checkw("s4_mod", O_MODULE_SELECT, ones);
    write_cfg(3'd3, rnd_sel(), rnd_sel(), 1'b1);
    checkw("s4_mod_hold", O_MODULE_SELECT, ones);
    send(3'd5, 4'hC, 40, l);
    send(3'd3, 4'hD, 40, l);
    checkw("s4_entry_kept_mod", O_MODULE_SELECT, ones);
    checkw("s4_entry_kept_slot", O_SLOT_SELECT, fives);

    // reset with five transfers in flight
    for (int t = 0; t < 5; t++) send(3'd3, 4'(t + 8), 4, l);
    tick();
    tick();
    #3;
    RST = 1'b1;
    #1;
    check1("mid_rst_ready", REQ_READY, 1'b0);
    check1("mid_rst_launch", O_LAUNCH, 1'b0);
    check1("mid_rst_done", O_DONE_VALID, 1'b0);
    check1("mid_rst_busy", O_BUSY, 1'b0);
    checkw("mid_rst_mod", O_MODULE_SELECT, '0);
    checkw("mid_rst_slot", O_SLOT_SELECT, '0);
    done_q.delete();
    m_valid = '0;
    tick();
    tick();
    RST = 1'b0;
    repeat (15) tick();
    write_cfg(3'd3, ones, fives, 1'b0);
    send(3'd3, 4'hA, 4, l);
    checkw("post_rst_mod", O_MODULE_SELECT, ones);
    checkw("post_rst_slot", O_SLOT_SELECT, fives);
    repeat (13) tick();

    // write bypass: unwritten entry written and requested in the same IDLE cycle
    send(3'd6, 4'h0, 40, l);
    bm = rnd_sel();
    bs = rnd_sel();
    CFG_WE = 1'b1; CFG_ADDR = 3'd2; CFG_MODULE_SEL = bm; CFG_SLOT_SEL = bs;
    REQ_VALID = 1'b1; REQ_IDX = 3'd2; REQ_TAG = 4'h3;
    #1;
    check1("bypass_ready", REQ_READY, 1'b1);
    tick();
    CFG_WE = 1'b0; REQ_VALID = 1'b0;
    checkw("bypass_mod", O_MODULE_SELECT, bm);
    checkw("bypass_slot", O_SLOT_SELECT, bs);

    // randomized reconfiguration rounds against the model
    for (int e = 0; e < CFG_DEPTH; e++) begin
      if (e != 2) write_cfg(3'(e), rnd_sel(), rnd_sel(), 1'b0);
    end
    begin
      int cur;
      cur = 2;
      for (int r = 0; r < 6; r++) begin
        int nidx, w, blen;
        nidx = int'($urandom_range(0, 7));
        while (nidx == cur) nidx = int'($urandom_range(0, 7));
        w = int'($urandom_range(0, 7));
        if (w != cur) write_cfg(3'(w), rnd_sel(), rnd_sel(), 1'b0);
        blen = int'($urandom_range(1, 4));
        for (int b = 0; b < blen; b++) begin
          send(3'(nidx), 4'($urandom_range(0, 15)), 40, l);
          if (b == 0) begin
            checkw("rnd_mod", O_MODULE_SELECT, m_mod[nidx]);
            checkw("rnd_slot", O_SLOT_SELECT, m_slot[nidx]);
          end
        end
        cur = nidx;
      end
    end
    repeat (NET_LATENCY + 4) tick();
    checkn("all_done_seen", done_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
